// File: rtl/clause_array_pkg.sv
// Shared encodings, state type and width helpers for the clause-array controller.
package clause_array_pkg;

  // 2-bit literal encoding stored in each row slot
  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_REPORT
  } state_e;

  // Bits needed to index n rows (at least one bit)
  function automatic int unsigned clause_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count 0..n rows
  function automatic int unsigned clause_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_NUM_CLAUSES = 8;
  localparam int unsigned CLAUSE_IDX_W    = clause_idx_w(DEF_NUM_CLAUSES);
  localparam int unsigned CLAUSE_CNT_W    = clause_cnt_w(DEF_NUM_CLAUSES);

endpackage

// File: rtl/clause_array_ctrl_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit plus an any-bit-set flag.
module lowest_set_idx
  import clause_array_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = clause_idx_w(W)
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clause_array_ctrl.sv
// Load / zero-fill / settle / report sequencer for one clause-array bank.
module clause_array_ctrl
  import clause_array_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES   = 8,
  parameter int unsigned NUM_LITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    load_start_i,
  input  logic                                    clause_valid_i,
  output logic                                    clause_ready_o,
  input  logic [NUM_LITS*2-1:0]                   clause_lits_i,
  input  logic                                    clause_last_i,
  output logic [NUM_CLAUSES-1:0]                  row_wr_o,
  output logic [NUM_LITS*2-1:0]                   row_lit_o,
  input  logic                                    bcp_start_i,
  output logic                                    imp_drv_o,
  input  logic [NUM_CLAUSES-1:0]                  row_cclause_i,
  input  logic [NUM_CLAUSES-1:0]                  row_clausesat_i,
  output logic                                    done_o,
  output logic                                    conflict_o,
  output logic [clause_idx_w(NUM_CLAUSES)-1:0]    conflict_idx_o,
  output logic                                    all_sat_o,
  output logic [clause_cnt_w(NUM_CLAUSES)-1:0]    clause_count_o,
  output logic                                    overflow_err_o
);

  localparam int unsigned IDX_W = clause_idx_w(NUM_CLAUSES);
  localparam int unsigned CNT_W = clause_cnt_w(NUM_CLAUSES);
  localparam int unsigned SET_W = clause_idx_w(SETTLE_CYCLES);
  localparam int unsigned LIT_W = NUM_LITS * 2;

  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(NUM_CLAUSES - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYCLES - 1);

  state_e                 state_q;
  logic [IDX_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       acc_cnt_q;
  logic [SET_W-1:0]       settle_cnt_q;
  logic                   loaded_q;
  logic [NUM_CLAUSES-1:0] valid_mask_q;
  logic [NUM_CLAUSES-1:0] row_wr_q;
  logic [LIT_W-1:0]       row_lit_q;
  logic                   imp_drv_q;
  logic                   done_q;
  logic                   conflict_q;
  logic [IDX_W-1:0]       conflict_idx_q;
  logic                   all_sat_q;
  logic [CNT_W-1:0]       clause_count_q;
  logic                   overflow_q;

  logic                   accept;
  logic [NUM_CLAUSES-1:0] row_sel_d;
  logic [NUM_CLAUSES-1:0] masked_cc;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
  logic                   all_sat_d;

  // Handshake, row select and result sampling terms
  assign clause_ready_o = (state_q == ST_LOAD);
  assign accept         = clause_valid_i & clause_ready_o;
  assign row_sel_d      = NUM_CLAUSES'(1) << wr_ptr_q;
  assign masked_cc      = row_cclause_i & valid_mask_q;
  assign all_sat_d      = &(row_clausesat_i | ~valid_mask_q);

  lowest_set_idx #(
    .W     (NUM_CLAUSES),
    .IDX_W (IDX_W)
  ) u_lowest (
    .vec_i (masked_cc),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Controller FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      acc_cnt_q      <= '0;
      settle_cnt_q   <= '0;
      loaded_q       <= 1'b0;
      valid_mask_q   <= '0;
      row_wr_q       <= '0;
      row_lit_q      <= '0;
      imp_drv_q      <= 1'b0;
      done_q         <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      all_sat_q      <= 1'b0;
      clause_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      row_wr_q <= '0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          imp_drv_q <= 1'b0;
          if (load_start_i) begin
            state_q        <= ST_LOAD;
            wr_ptr_q       <= '0;
            acc_cnt_q      <= '0;
            loaded_q       <= 1'b0;
            valid_mask_q   <= '0;
            overflow_q     <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            all_sat_q      <= 1'b0;
          end else if (bcp_start_i && loaded_q) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            imp_drv_q    <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            row_wr_q               <= row_sel_d;
            row_lit_q              <= clause_lits_i;
            valid_mask_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q               <= wr_ptr_q + IDX_W'(1);
            acc_cnt_q              <= acc_cnt_q + CNT_W'(1);
            if (wr_ptr_q == LAST_ROW) begin
              // Bank full: no zero-fill needed; missing last flags overflow
              state_q        <= ST_IDLE;
              loaded_q       <= 1'b1;
              clause_count_q <= CNT_W'(NUM_CLAUSES);
              overflow_q     <= ~clause_last_i;
            end else if (clause_last_i) begin
              state_q <= ST_CLEAR;
            end
          end
        end

        ST_CLEAR: begin
          row_wr_q  <= row_sel_d;
          row_lit_q <= {NUM_LITS{LIT_NONE}};
          wr_ptr_q  <= wr_ptr_q + IDX_W'(1);
          if (wr_ptr_q == LAST_ROW) begin
            state_q        <= ST_IDLE;
            loaded_q       <= 1'b1;
            clause_count_q <= acc_cnt_q;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_END) begin
            state_q <= ST_REPORT;
          end else begin
            settle_cnt_q <= settle_cnt_q + SET_W'(1);
          end
        end

        ST_REPORT: begin
          conflict_q     <= enc_any;
          conflict_idx_q <= enc_idx;
          all_sat_q      <= all_sat_d;
          done_q         <= 1'b1;
          imp_drv_q      <= 1'b0;
          state_q        <= ST_IDLE;
        end

        default: begin
          state_q   <= ST_IDLE;
          imp_drv_q <= 1'b0;
        end
      endcase
    end
  end

  assign row_wr_o       = row_wr_q;
  assign row_lit_o      = row_lit_q;
  assign imp_drv_o      = imp_drv_q;
  assign done_o         = done_q;
  assign conflict_o     = conflict_q;
  assign conflict_idx_o = conflict_idx_q;
  assign all_sat_o      = all_sat_q;
  assign clause_count_o = clause_count_q;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_clause_array_ctrl.sv
// Scoreboard bench for clause_array_ctrl (8 rows, 8 literals, settle 4).
module tb_clause_array_ctrl;

  logic        clk;
  logic        rst;
  logic        load_start_i;
  logic        clause_valid_i;
  logic        clause_ready_o;
  logic [15:0] clause_lits_i;
  logic        clause_last_i;
  logic [7:0]  row_wr_o;
  logic [15:0] row_lit_o;
  logic        bcp_start_i;
  logic        imp_drv_o;
  logic [7:0]  row_cclause_i;
  logic [7:0]  row_clausesat_i;
  logic        done_o;
  logic        conflict_o;
  logic [2:0]  conflict_idx_o;
  logic        all_sat_o;
  logic [3:0]  clause_count_o;
  logic        overflow_err_o;

  int total;
  int bad;
  int done_cnt;

  logic [23:0] wr_q[$];
  logic [4:0]  res_q[$];
  logic [23:0] mon_ew;
  logic [4:0]  mon_er;

  clause_array_ctrl #(
    .NUM_CLAUSES   (8),
    .NUM_LITS      (8),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_start_i    (load_start_i),
    .clause_valid_i  (clause_valid_i),
    .clause_ready_o  (clause_ready_o),
    .clause_lits_i   (clause_lits_i),
    .clause_last_i   (clause_last_i),
    .row_wr_o        (row_wr_o),
    .row_lit_o       (row_lit_o),
    .bcp_start_i     (bcp_start_i),
    .imp_drv_o       (imp_drv_o),
    .row_cclause_i   (row_cclause_i),
    .row_clausesat_i (row_clausesat_i),
    .done_o          (done_o),
    .conflict_o      (conflict_o),
    .conflict_idx_o  (conflict_idx_o),
    .all_sat_o       (all_sat_o),
    .clause_count_o  (clause_count_o),
    .overflow_err_o  (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop and compare whenever the DUT writes a row or reports a result
  always @(negedge clk) begin
    if (!rst) begin
      if (row_wr_o != 8'h00) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL row_write_unexpected: got wr=%h lit=%h, expected no write", row_wr_o, row_lit_o);
        end else begin
          mon_ew = wr_q.pop_front();
          if ({row_wr_o, row_lit_o} !== mon_ew)
            begin
              bad++;
              $display("FAIL row_write: got wr=%h lit=%h, expected wr=%h lit=%h",
                       row_wr_o, row_lit_o, mon_ew[23:16], mon_ew[15:0]);
            end
        end
      end
      if (done_o) begin
        done_cnt++;
        total++;
        if (res_q.size() == 0) begin
          bad++;
          $display("FAIL result_unexpected: got done with conf=%b idx=%0d sat=%b, expected no done",
                   conflict_o, conflict_idx_o, all_sat_o);
        end else begin
          mon_er = res_q.pop_front();
          if ({conflict_o, conflict_idx_o, all_sat_o} !== mon_er) begin
            bad++;
            $display("FAIL result: got conf=%b idx=%0d sat=%b, expected conf=%b idx=%0d sat=%b",
                     conflict_o, conflict_idx_o, all_sat_o, mon_er[4], mon_er[3:1], mon_er[0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  // Offer one clause and hold it until accepted (bounded)
  task automatic send(input logic [15:0] lits, input logic last, input logic [7:0] row);
    logic ok;
    int   n;
    wr_q.push_back({row, lits});
    clause_valid_i = 1'b1;
    clause_lits_i  = lits;
    clause_last_i  = last;
    n = 0;
    do begin
      ok = clause_ready_o;
      tick();
      n++;
    end while (!ok && n < 20);
    clause_valid_i = 1'b0;
    clause_last_i  = 1'b0;
    check("clause_accepted", 32'(ok), 32'd1);
  endtask

  // Three-clause load, optional gaps between valids
  task automatic load3(input int gap, input bit do_start);
    if (do_start) start_load();
    send(16'h0001, 1'b0, 8'h01);
    repeat (gap) tick();
    send(16'h0006, 1'b0, 8'h02);
    repeat (gap) tick();
    send(16'h0009, 1'b1, 8'h04);
    check("ready_drop_in_clear", 32'(clause_ready_o), 32'd0);
    for (int r = 3; r < 8; r++) wr_q.push_back({8'(1 << r), 16'h0000});
    repeat (8) tick();
    check("load3_count", 32'(clause_count_o), 32'd3);
    check("load3_overflow", 32'(overflow_err_o), 32'd0);
    check("load3_ready_idle", 32'(clause_ready_o), 32'd0);
    check("load3_writes_seen", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic run_bcp(input logic [7:0] cc, input logic [7:0] sat,
                         input logic econf, input logic [2:0] eidx, input logic esat);
    int imp_n;
    int done_at;
    row_cclause_i   = cc;
    row_clausesat_i = sat;
    res_q.push_back({econf, eidx, esat});
    bcp_start_i = 1'b1;
    tick();
    bcp_start_i = 1'b0;
    imp_n   = 0;
    done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      if (imp_drv_o) imp_n++;
      if (done_o && done_at == 0) done_at = k;
      tick();
    end
    check("imp_drv_cycles", 32'(imp_n), 32'd5);
    check("done_latency", 32'(done_at), 32'd6);
    check("result_seen", 32'(res_q.size()), 32'd0);
    check("hold_conflict", 32'(conflict_o), 32'(econf));
    check("hold_all_sat", 32'(all_sat_o), 32'(esat));
  endtask

  initial begin
    int d0;
    total = 0; bad = 0; done_cnt = 0;
    rst = 1'b1;
    load_start_i = 1'b0; clause_valid_i = 1'b0; clause_lits_i = '0; clause_last_i = 1'b0;
    bcp_start_i = 1'b0; row_cclause_i = '0; row_clausesat_i = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 32'(clause_ready_o), 32'd0);
    check("rst_row_wr", 32'(row_wr_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_count", 32'(clause_count_o), 32'd0);

    // Three-clause load, then conflict report and masking
    load3(0, 1'b1);
    run_bcp(8'b0010_0110, 8'h01, 1'b1, 3'd1, 1'b0);
    run_bcp(8'h20, 8'h07, 1'b0, 3'd0, 1'b1);

    // Asynchronous reset mid-cycle during a load
    start_load();
    check("load_ready_before_rst", 32'(clause_ready_o), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 32'(clause_ready_o), 32'd0);
    check("arst_count", 32'(clause_count_o), 32'd0);
    check("arst_all_sat", 32'(all_sat_o), 32'd0);
    check("arst_row_lit", 32'(row_lit_o), 32'd0);
    check("arst_imp", 32'(imp_drv_o), 32'd0);
    #2 rst = 1'b0;
    tick();
    d0 = done_cnt;
    bcp_start_i = 1'b1;
    tick();
    bcp_start_i = 1'b0;
    repeat (10) tick();
    check("bcp_ignored_unloaded", 32'(done_cnt), 32'(d0));
    check("bcp_ignored_imp", 32'(imp_drv_o), 32'd0);

    // Backpressure: two idle cycles between valids
    load3(2, 1'b1);

    // Overflow: eight clauses with no last
    start_load();
    for (int i = 0; i < 8; i++) send(16'(16'hA500 + i), 1'b0, 8'(1 << i));
    check("ovf_ready", 32'(clause_ready_o), 32'd0);
    repeat (3) tick();
    check("ovf_err", 32'(overflow_err_o), 32'd1);
    check("ovf_count", 32'(clause_count_o), 32'd8);
    check("ovf_writes_seen", 32'(wr_q.size()), 32'd0);
    start_load();
    check("ovf_cleared", 32'(overflow_err_o), 32'd0);
    check("results_cleared", 32'(all_sat_o), 32'd0);
    load3(0, 1'b0);

    // Reset during the settle window
    d0 = done_cnt;
    bcp_start_i = 1'b1;
    tick();
    bcp_start_i = 1'b0;
    tick();
    check("settle_imp_high", 32'(imp_drv_o), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("settle_rst_imp", 32'(imp_drv_o), 32'd0);
    #2 rst = 1'b0;
    repeat (12) tick();
    check("settle_rst_no_done", 32'(done_cnt), 32'(d0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
